// File: rtl/counter_adder_pkg.sv
// Shared definitions for the counter/adder stimulus block.
//   mode_e : counter mode encoding carried on the 2-bit mode port
package counter_adder_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_HOLD = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/ripple_adder.sv
// W-bit ripple-carry adder built from a chain of full-adder cells.
//   a, b : W-bit operands
//   cin  : carry into bit 0
//   s    : W-bit sum
//   cout : carry out of bit W-1
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module ripple_adder #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (s[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[W];

endmodule

// File: rtl/counter_adder_gen.sv
// 2*W-bit up/down/hold/load counter feeding a W-bit adder that sums the
// low and high halves of the count plus a carry-in. All outputs registered.
//   clock    : clock, all state changes on posedge
//   clear    : synchronous active-low reset
//   en       : advance enable; when low all state holds, valid/wrap drop
//   mode     : 00 up, 01 down, 10 hold, 11 load
//   load_val : value loaded in load mode
//   cin      : adder carry-in
//   cnt      : counter value
//   sum/cout : adder result for the count before the last enabled edge
//   valid    : high in the cycle after an enabled edge
//   wrap     : one-cycle pulse when the last edge wrapped the count
module counter_adder_gen
  import counter_adder_pkg::*;
#(
  parameter int unsigned W    = 2,
  parameter int unsigned STEP = 1
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic [2*W-1:0] load_val,
  input  logic           cin,
  output logic [2*W-1:0] cnt,
  output logic [W-1:0]   sum,
  output logic           cout,
  output logic           valid,
  output logic           wrap
);

  localparam int unsigned CW = 2 * W;

  logic [CW-1:0] cnt_nxt;
  logic          wrap_nxt;
  logic [CW:0]   up_full;
  logic [W-1:0]  add_s;
  logic          add_c;

  // Extra bit of the up-count result is the wrap indication.
  assign up_full = {1'b0, cnt} + (CW+1)'(STEP);

  // Next count and wrap flag for an enabled edge.
  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    case (mode_e'(mode))
      MODE_UP: begin
        cnt_nxt  = up_full[CW-1:0];
        wrap_nxt = up_full[CW];
      end
      MODE_DOWN: begin
        cnt_nxt  = cnt - CW'(STEP);
        wrap_nxt = (cnt < CW'(STEP));
      end
      MODE_HOLD: cnt_nxt = cnt;
      MODE_LOAD: cnt_nxt = load_val;
      default:   cnt_nxt = cnt;
    endcase
  end

  // Adder operates on the pre-edge count so sum/cout lag cnt by one enabled cycle.
  ripple_adder #(.W(W)) u_adder (
    .a    (cnt[W-1:0]),
    .b    (cnt[CW-1:W]),
    .cin  (cin),
    .s    (add_s),
    .cout (add_c)
  );

  // Counter and output registers; clear overrides every other input.
  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (en) begin
      cnt   <= cnt_nxt;
      sum   <= add_s;
      cout  <= add_c;
      valid <= 1'b1;
      wrap  <= wrap_nxt;
    end else begin
      valid <= 1'b0;
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_adder_gen.sv
// Directed bench for counter_adder_gen: one instance with STEP=1 and a
// second with STEP=3 sharing the same stimulus.
module tb_counter_adder_gen;

  logic       clock = 1'b0;
  logic       clear;
  logic       en;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic       cin;

  logic [3:0] cnt,  cnt3;
  logic [1:0] sum,  sum3;
  logic       cout, cout3;
  logic       valid, valid3;
  logic       wrap, wrap3;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  counter_adder_gen #(.W(2), .STEP(1)) u_dut (
    .clock(clock), .clear(clear), .en(en), .mode(mode), .load_val(load_val),
    .cin(cin), .cnt(cnt), .sum(sum), .cout(cout), .valid(valid), .wrap(wrap)
  );

  counter_adder_gen #(.W(2), .STEP(3)) u_dut3 (
    .clock(clock), .clear(clear), .en(en), .mode(mode), .load_val(load_val),
    .cin(cin), .cnt(cnt3), .sum(sum3), .cout(cout3), .valid(valid3), .wrap(wrap3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one posedge and sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic [1:0] s,
                         input logic co, input logic v, input logic w);
    chk({tag, ".cnt"},   32'(cnt),   32'(c));
    chk({tag, ".sum"},   32'(sum),   32'(s));
    chk({tag, ".cout"},  32'(cout),  32'(co));
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".wrap"},  32'(wrap),  32'(w));
  endtask

  initial begin
    logic [3:0] prev;
    logic [2:0] full;

    // 1. reset with a pending load
    clear = 1'b0; en = 1'b1; mode = 2'b11; load_val = 4'hA; cin = 1'b0;
    tick();
    tick();
    chk_all("reset", 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("reset.cnt3", 32'(cnt3), 32'h0);

    // 2. up count 0..15 then 0
    clear = 1'b1; mode = 2'b00; cin = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      prev = 4'(i - 1);
      full = 3'({1'b0, prev[1:0]}) + 3'({1'b0, prev[3:2]});
      chk($sformatf("up%0d.cnt", i),  32'(cnt),  32'(i % 16));
      chk($sformatf("up%0d.wrap", i), 32'(wrap), 32'(i == 16));
      chk($sformatf("up%0d.sum", i),  32'({cout, sum}), 32'(full));
    end
    chk_all("up_last", 4'h0, 2'b10, 1'b1, 1'b1, 1'b1);
    tick();
    chk("up_after.wrap", 32'(wrap), 32'h0);
    chk("up_after.cnt",  32'(cnt),  32'h1);

    // 3. load 4'hB with cin=1, then hold to see 3+2+1
    mode = 2'b11; load_val = 4'hB; cin = 1'b1;
    tick();
    chk_all("load", 4'hB, 2'b10, 1'b0, 1'b1, 1'b0); // prev cnt=1: 1+0+1=2
    mode = 2'b10;
    tick();
    chk_all("load_sum", 4'hB, 2'b10, 1'b1, 1'b1, 1'b0);

    // 4. down mode: STEP=1 from 1 -> 0 -> F; STEP=3 from 1 -> E -> B
    mode = 2'b11; load_val = 4'h1; cin = 1'b0;
    tick();
    chk("dn_ld.cnt", 32'(cnt), 32'h1);
    chk("dn_ld.cnt3", 32'(cnt3), 32'h1);
    mode = 2'b01;
    tick();
    chk("dn1.cnt",   32'(cnt),   32'h0);
    chk("dn1.wrap",  32'(wrap),  32'h0);
    chk("dn1.cnt3",  32'(cnt3),  32'hE);
    chk("dn1.wrap3", 32'(wrap3), 32'h1);
    tick();
    chk("dn2.cnt",   32'(cnt),   32'hF);
    chk("dn2.wrap",  32'(wrap),  32'h1);
    chk("dn2.cnt3",  32'(cnt3),  32'hB);
    chk("dn2.wrap3", 32'(wrap3), 32'h0);
    mode = 2'b10;
    tick();
    chk("dn3.cnt",  32'(cnt),  32'hF);
    chk("dn3.wrap", 32'(wrap), 32'h0);

    // 5. load 5, then en=0 for 3 cycles, then hold
    mode = 2'b11; load_val = 4'h5; cin = 1'b0;
    tick();
    chk_all("ld5", 4'h5, 2'b10, 1'b1, 1'b1, 1'b0); // prev F: 3+3=6
    en = 1'b0; mode = 2'b00; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("idle%0d", i), 4'h5, 2'b10, 1'b1, 1'b0, 1'b0);
    end
    en = 1'b1; mode = 2'b10; cin = 1'b0;
    tick();
    chk_all("hold5", 4'h5, 2'b10, 1'b0, 1'b1, 1'b0); // 1+1+0=2

    // 6. clear mid-count beats a concurrent load
    mode = 2'b01;
    tick();
    chk("mid.cnt", 32'(cnt), 32'h4);
    clear = 1'b0; mode = 2'b11; load_val = 4'h7; cin = 1'b1;
    tick();
    chk_all("clr_ld", 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("clr_ld.cnt3", 32'(cnt3), 32'h0);
    tick();
    chk_all("clr_hold", 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
